pdm_capture_ctrl: RTL and testbench
===================================

// Module: pdm_capture_ctrl
// PURPOSE
//  Sequences one capture burst from the PDM microphone front end: enables the mic clock,
//  waits out mic start-up, accepts NUM_SAMPLES decimated amplitudes, then disables the mic.
//  Sits between the PDM decimator (amplitude/valid) and the downstream consumer, buffering
//  samples in a small FIFO behind a valid/ready stream. Reports busy/done/overflow status.
// PARAMETERS
//  CLK_FREQ       125      system clock, MHz (documentation / warm-up derivation only)
//  WARMUP_CYCLES  1250000  CLK_IN cycles with MIC_EN high before samples are accepted (10 ms)
//  SAMPLE_W       7        amplitude width, bits
//  FIFO_DEPTH     16       sample buffer entries, power of two, >= 2
//  CNT_W          16       width of sample-count request
// PORTS
//  CLK_IN        in   1         system clock; all logic on rising edge
//  RST_N         in   1         asynchronous, active-low reset
//  START         in   1         begin burst; honoured only in IDLE
//  STOP          in   1         abort burst; honoured in WARMUP/CAPTURE, ignored otherwise
//  NUM_SAMPLES   in   CNT_W     samples per burst, latched on START; 0 = run until STOP
//  MIC_EN        out  1         gate for mic clock generator
//  AMP_IN        in   SAMPLE_W  decimator amplitude
//  AMP_VALID     in   1         one-cycle strobe qualifying AMP_IN
//  S_DATA        out  SAMPLE_W  FIFO head (show-ahead)
//  S_VALID       out  1         FIFO non-empty
//  S_READY       in   1         consumer accepts S_DATA when S_VALID & S_READY
//  BUSY          out  1         state != IDLE
//  DONE          out  1         one-cycle pulse on return to IDLE
//  OVERFLOW      out  1         sticky: a sample was dropped; cleared on accepted START
//  STATE         out  2         IDLE=0, WARMUP=1, CAPTURE=2, DRAIN=3
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, counters 0; reset mid-burst drops FIFO contents.
//  IDLE: START -> WARMUP next cycle; latch NUM_SAMPLES; clear OVERFLOW, warm-up and sample counters.
//    START & STOP same cycle in IDLE: START wins.
//  WARMUP: MIC_EN=1; count CLK_IN cycles; AMP_VALID ignored (not pushed, not counted).
//    count == WARMUP_CYCLES-1 -> CAPTURE. STOP -> DRAIN (FIFO empty), MIC_EN=0 next cycle.
//  CAPTURE: MIC_EN=1; each AMP_VALID increments sample count and pushes AMP_IN.
//    Push with FIFO full and no same-cycle pop: sample dropped, OVERFLOW<=1, still counted.
//    Full FIFO with same-cycle pop: push accepted.
//    count reaches NUM_SAMPLES (on the strobe that completes it) or STOP -> DRAIN, MIC_EN=0 next cycle.
//    STOP coincident with a final AMP_VALID: that sample is pushed, then DRAIN.
//    NUM_SAMPLES=0: count wraps at 2^CNT_W silently; exit only via STOP.
//  DRAIN: MIC_EN=0; AMP_VALID ignored; wait until FIFO empty, then DONE=1 one cycle and IDLE.
//    START/STOP ignored in DRAIN.
//  Stream: S_DATA/S_VALID registered from FIFO; AMP_VALID at cycle t into empty FIFO -> S_VALID at t+1.
//    S_DATA stable while S_VALID & !S_READY. Pops independent of state, so drain is consumer-paced.
//  Throughput: one push and one pop per cycle; no bubbles at full/empty boundaries.
// STRUCTURE
//  Shared package/include pdm_pkg: STATE encodings, SAMPLE_W default, mic warm-up constant.
//  One sub-module: pdm_sample_fifo (sync FIFO, show-ahead, DEPTH/WIDTH params, push/pop/full/empty, async RST_N).
//  FSM, warm-up counter, sample counter, status flags in this module.
// TESTING
//  WARMUP_CYCLES=8, NUM_SAMPLES=4, S_READY=1, AMP_VALID every 5 cycles with 1,2,3,4 -> S_DATA 1,2,3,4;
//    MIC_EN high 8 cycles before first push; one DONE pulse; STATE ends 0.
//  AMP_VALID pulses during WARMUP -> nothing in FIFO, sample count 0 at CAPTURE entry.
//  S_READY=0, 20 samples, FIFO_DEPTH=16 -> OVERFLOW=1 after 17th; S_DATA then 1..16 in order;
//    DONE only after 16th pop; next START clears OVERFLOW.
//  NUM_SAMPLES=0, STOP after 7 samples -> MIC_EN falls next cycle, exactly 7 samples out, DONE.
//  STOP in WARMUP cycle 3 -> DRAIN, DONE two cycles later, no S_VALID.
//  RST_N low mid-CAPTURE with 5 buffered -> S_VALID, MIC_EN, BUSY 0 immediately; START after release works.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM capture path: FSM encodings, default sample
// width, and the mic start-up time expressed in system clock cycles.
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int SAMPLE_W_DEF  = 7;
  localparam int CLK_FREQ_DEF  = 125;  // MHz
  localparam int MIC_WARMUP_MS = 10;

  // Mic start-up time in cycles of a clk_mhz system clock.
  function automatic int mic_warmup_cycles(input int clk_mhz);
    return clk_mhz * MIC_WARMUP_MS * 1000;
  endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous show-ahead FIFO. Head entry is presented on rd_data whenever
// empty is low. A push into a full FIFO is accepted only if a pop happens in
// the same cycle, so a full FIFO still sustains one push and one pop per cycle.
module pdm_sample_fifo
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7
)(
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; reset discards any buffered samples.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// Capture burst sequencer: powers the mic, waits out its start-up, collects a
// requested number of decimated samples into a FIFO, then powers the mic down
// and waits for the consumer to empty the FIFO before reporting DONE.
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int CLK_FREQ      = CLK_FREQ_DEF,
  parameter int WARMUP_CYCLES = mic_warmup_cycles(CLK_FREQ),
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_W         = 16
)(
  input  logic                CLK_IN,
  input  logic                RST_N,
  input  logic                START,
  input  logic                STOP,
  input  logic [CNT_W-1:0]    NUM_SAMPLES,
  output logic                MIC_EN,
  input  logic [SAMPLE_W-1:0] AMP_IN,
  input  logic                AMP_VALID,
  output logic [SAMPLE_W-1:0] S_DATA,
  output logic                S_VALID,
  input  logic                S_READY,
  output logic                BUSY,
  output logic                DONE,
  output logic                OVERFLOW,
  output logic [1:0]          STATE
);

  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  state_t           state, nxt;
  logic [CNT_W-1:0] num_q, smp_cnt;
  logic [WW-1:0]    warm_cnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop, start_acc, warm_last, capture_done;

  // Only CAPTURE feeds the FIFO; pops follow the stream handshake in any state.
  assign push      = (state == ST_CAPTURE) & AMP_VALID;
  assign pop       = S_VALID & S_READY;
  assign drop      = push & fifo_full & ~pop;
  assign start_acc = (state == ST_IDLE) & START;
  assign warm_last = (warm_cnt == WW'(WARMUP_CYCLES - 1));
  // NUM_SAMPLES == 0 means free-running: the count wraps and never matches.
  assign capture_done = push & (num_q != '0) & ((smp_cnt + CNT_W'(1)) == num_q);

  assign S_VALID = ~fifo_empty;
  assign MIC_EN  = (state == ST_WARMUP) | (state == ST_CAPTURE);
  assign BUSY    = (state != ST_IDLE);
  assign STATE   = state;

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .CLK_IN    (CLK_IN),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (AMP_IN),
    .pop       (pop),
    .rd_data   (S_DATA),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state: START beats STOP in IDLE; START/STOP are ignored in DRAIN.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (START) nxt = ST_WARMUP;
      ST_WARMUP:  if (STOP) nxt = ST_DRAIN;
                  else if (warm_last) nxt = ST_CAPTURE;
      ST_CAPTURE: if (STOP || capture_done) nxt = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // Burst counters and latched request, all restarted by an accepted START.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      warm_cnt <= '0;
      smp_cnt  <= '0;
      num_q    <= '0;
    end else if (start_acc) begin
      warm_cnt <= '0;
      smp_cnt  <= '0;
      num_q    <= NUM_SAMPLES;
    end else begin
      if (state == ST_WARMUP) warm_cnt <= warm_cnt + WW'(1);
      if (push)               smp_cnt  <= smp_cnt + CNT_W'(1);
    end
  end

  // Status: sticky overflow, and a one-cycle DONE on the DRAIN -> IDLE step.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      if (start_acc) OVERFLOW <= 1'b0;
      else if (drop) OVERFLOW <= 1'b1;
      DONE <= (state == ST_DRAIN) & fifo_empty;
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with a short warm-up (8 cycles).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_pdm_capture_ctrl;

  localparam int SW = 7;
  localparam int CW = 16;

  logic          CLK_IN = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0, STOP = 1'b0;
  logic [CW-1:0] NUM_SAMPLES = '0;
  logic          MIC_EN;
  logic [SW-1:0] AMP_IN = '0;
  logic          AMP_VALID = 1'b0;
  logic [SW-1:0] S_DATA;
  logic          S_VALID;
  logic          S_READY = 1'b0;
  logic          BUSY, DONE, OVERFLOW;
  logic [1:0]    STATE;

  int total = 0;
  int bad = 0;

  pdm_capture_ctrl #(
    .CLK_FREQ(125), .WARMUP_CYCLES(8), .SAMPLE_W(SW), .FIFO_DEPTH(16), .CNT_W(CW)
  ) dut (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .START(START), .STOP(STOP),
    .NUM_SAMPLES(NUM_SAMPLES), .MIC_EN(MIC_EN), .AMP_IN(AMP_IN),
    .AMP_VALID(AMP_VALID), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_READY(S_READY), .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW),
    .STATE(STATE)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  // Steps until STATE == s or the cycle budget runs out; ok reports which.
  task automatic wait_state(input logic [1:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (STATE === s) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #3;
    total++; if ({STATE, BUSY, MIC_EN, S_VALID, DONE, OVERFLOW} !== 7'd0) begin bad++; $display("FAIL reset_flags act=%b exp=0", {STATE, BUSY, MIC_EN, S_VALID, DONE, OVERFLOW}); end
    total++; if (S_DATA !== 7'd0) begin bad++; $display("FAIL reset_sdata act=%0d exp=0", S_DATA); end
    step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int n;
    S_READY = 1'b1; NUM_SAMPLES = 16'd4; START = 1'b1;
    step();
    START = 1'b0;
    n = 0;
    while (STATE === 2'd1 && MIC_EN === 1'b1 && n < 40) begin n++; step(); end
    total++; if (n != 8) begin bad++; $display("FAIL basic_warmup_len act=%0d exp=8", n); end
    total++; if (STATE !== 2'd2 || MIC_EN !== 1'b1) begin bad++; $display("FAIL basic_capture_entry act=%0d/%b exp=2/1", STATE, MIC_EN); end
    for (int k = 1; k <= 4; k++) begin
      AMP_VALID = 1'b1; AMP_IN = SW'(k);
      step();
      AMP_VALID = 1'b0;
      total++; if (S_VALID !== 1'b1 || S_DATA !== SW'(k)) begin bad++; $display("FAIL basic_data act=%b/%0d exp=1/%0d", S_VALID, S_DATA, k); end
      if (k < 4) repeat (4) step();
    end
    total++; if (STATE !== 2'd3 || MIC_EN !== 1'b0) begin bad++; $display("FAIL basic_drain act=%0d/%b exp=3/0", STATE, MIC_EN); end
    step();
    total++; if (S_VALID !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL basic_popped act=%b/%b exp=0/0", S_VALID, DONE); end
    step();
    total++; if (DONE !== 1'b1 || STATE !== 2'd0) begin bad++; $display("FAIL basic_done act=%b/%0d exp=1/0", DONE, STATE); end
    step();
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL basic_done_pulse act=%b exp=0", DONE); end
  endtask

  task automatic test_warmup_ignore();
    bit ok;
    S_READY = 1'b1; NUM_SAMPLES = 16'd2; START = 1'b1;
    step();
    START = 1'b0;
    AMP_IN = 7'd9;
    for (int i = 0; i < 40 && STATE === 2'd1; i++) begin
      AMP_VALID = 1'b1;
      step();
      total++; if (S_VALID !== 1'b0) begin bad++; $display("FAIL warm_push act=%b exp=0", S_VALID); end
    end
    AMP_VALID = 1'b0;
    total++; if (STATE !== 2'd2) begin bad++; $display("FAIL warm_to_capture act=%0d exp=2", STATE); end
    AMP_VALID = 1'b1; AMP_IN = 7'd10;
    step();
    AMP_VALID = 1'b0;
    total++; if (STATE !== 2'd2 || S_DATA !== 7'd10) begin bad++; $display("FAIL warm_first act=%0d/%0d exp=2/10", STATE, S_DATA); end
    step();
    AMP_VALID = 1'b1; AMP_IN = 7'd11;
    step();
    AMP_VALID = 1'b0;
    total++; if (STATE !== 2'd3 || S_DATA !== 7'd11) begin bad++; $display("FAIL warm_second act=%0d/%0d exp=3/11", STATE, S_DATA); end
    wait_state(2'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL warm_idle_timeout act=%0d exp=0", STATE); end
    step();
  endtask

  task automatic test_overflow();
    bit ok;
    S_READY = 1'b0; NUM_SAMPLES = 16'd20; START = 1'b1;
    step();
    START = 1'b0;
    wait_state(2'd2, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_capture_timeout act=%0d exp=2", STATE); end
    for (int k = 1; k <= 20; k++) begin
      AMP_VALID = 1'b1; AMP_IN = SW'(k);
      step();
      if (k == 16) begin total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_early act=%b exp=0", OVERFLOW); end end
      if (k == 17) begin total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_set act=%b exp=1", OVERFLOW); end end
    end
    AMP_VALID = 1'b0;
    total++; if (STATE !== 2'd3) begin bad++; $display("FAIL ovf_drain act=%0d exp=3", STATE); end
    S_READY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      total++; if (S_VALID !== 1'b1 || S_DATA !== SW'(i) || DONE !== 1'b0) begin bad++; $display("FAIL ovf_order act=%b/%0d/%b exp=1/%0d/0", S_VALID, S_DATA, DONE, i); end
      step();
    end
    total++; if (S_VALID !== 1'b0 || DONE !== 1'b0 || STATE !== 2'd3) begin bad++; $display("FAIL ovf_empty act=%b/%b/%0d exp=0/0/3", S_VALID, DONE, STATE); end
    step();
    total++; if (DONE !== 1'b1 || OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_done act=%b/%b exp=1/1", DONE, OVERFLOW); end
    START = 1'b1; STOP = 1'b1;
    step();
    START = 1'b0;
    total++; if (STATE !== 2'd1 || OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_restart act=%0d/%b exp=1/0", STATE, OVERFLOW); end
    step();
    STOP = 1'b0;
    wait_state(2'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_idle_timeout act=%0d exp=0", STATE); end
    step();
  endtask

  task automatic test_free_run();
    bit ok;
    S_READY = 1'b1; NUM_SAMPLES = 16'd0; START = 1'b1;
    step();
    START = 1'b0;
    wait_state(2'd2, ok);
    total++; if (!ok) begin bad++; $display("FAIL free_capture_timeout act=%0d exp=2", STATE); end
    for (int k = 0; k < 7; k++) begin
      AMP_VALID = 1'b1; AMP_IN = SW'(21 + k); STOP = (k == 6);
      step();
      AMP_VALID = 1'b0; STOP = 1'b0;
      total++; if (S_VALID !== 1'b1 || S_DATA !== SW'(21 + k)) begin bad++; $display("FAIL free_data act=%b/%0d exp=1/%0d", S_VALID, S_DATA, 21 + k); end
      if (k < 6) begin
        total++; if (MIC_EN !== 1'b1) begin bad++; $display("FAIL free_mic_on act=%b exp=1", MIC_EN); end
        step();
      end
    end
    total++; if (MIC_EN !== 1'b0 || STATE !== 2'd3) begin bad++; $display("FAIL free_stop act=%b/%0d exp=0/3", MIC_EN, STATE); end
    step();
    total++; if (S_VALID !== 1'b0) begin bad++; $display("FAIL free_extra act=%b exp=0", S_VALID); end
    step();
    total++; if (DONE !== 1'b1 || STATE !== 2'd0) begin bad++; $display("FAIL free_done act=%b/%0d exp=1/0", DONE, STATE); end
    step();
  endtask

  task automatic test_stop_warmup();
    S_READY = 1'b1; NUM_SAMPLES = 16'd5; START = 1'b1;
    step();
    START = 1'b0;
    step(); step();
    total++; if (STATE !== 2'd1) begin bad++; $display("FAIL sw_in_warmup act=%0d exp=1", STATE); end
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    total++; if (STATE !== 2'd3 || MIC_EN !== 1'b0 || S_VALID !== 1'b0) begin bad++; $display("FAIL sw_drain act=%0d/%b/%b exp=3/0/0", STATE, MIC_EN, S_VALID); end
    step();
    total++; if (DONE !== 1'b1 || STATE !== 2'd0 || S_VALID !== 1'b0) begin bad++; $display("FAIL sw_done act=%b/%0d/%b exp=1/0/0", DONE, STATE, S_VALID); end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    S_READY = 1'b0; NUM_SAMPLES = 16'd10; START = 1'b1;
    step();
    START = 1'b0;
    wait_state(2'd2, ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_capture_timeout act=%0d exp=2", STATE); end
    for (int k = 1; k <= 5; k++) begin
      AMP_VALID = 1'b1; AMP_IN = SW'(k);
      step();
    end
    AMP_VALID = 1'b0;
    total++; if (S_VALID !== 1'b1 || S_DATA !== 7'd1) begin bad++; $display("FAIL rm_buffered act=%b/%0d exp=1/1", S_VALID, S_DATA); end
    #2 RST_N = 1'b0;
    #1;
    total++; if (S_VALID !== 1'b0 || MIC_EN !== 1'b0 || BUSY !== 1'b0 || STATE !== 2'd0) begin bad++; $display("FAIL rm_async act=%b/%b/%b/%0d exp=0/0/0/0", S_VALID, MIC_EN, BUSY, STATE); end
    #3 RST_N = 1'b1;
    step();
    S_READY = 1'b1; NUM_SAMPLES = 16'd1; START = 1'b1;
    step();
    START = 1'b0;
    wait_state(2'd2, ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_restart_timeout act=%0d exp=2", STATE); end
    AMP_VALID = 1'b1; AMP_IN = 7'd42;
    step();
    AMP_VALID = 1'b0;
    total++; if (S_VALID !== 1'b1 || S_DATA !== 7'd42 || STATE !== 2'd3) begin bad++; $display("FAIL rm_after act=%b/%0d/%0d exp=1/42/3", S_VALID, S_DATA, STATE); end
    step(); step();
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL rm_done act=%b exp=1", DONE); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_warmup_ignore();
    test_overflow();
    test_free_run();
    test_stop_warmup();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
